uart_param: RTL and testbench



---
 rtl/uart_param.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_param
// Function : Full-duplex UART, 16x oversampled RX, valid/ready TX, 5..9 data
//            bits, optional odd/even parity, 1 or 2 stop bits.
// Revision : 1.0  initial release
// ============================================================================
module uart_param #(
  parameter int CLK_DIV    = 27,
  parameter int DATA_BITS  = 9,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_out,
  output logic                 tx_busy,
  input  logic                 rx_in,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int             c_cw        = $clog2(16 * CLK_DIV);
  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(16 * CLK_DIV - 1);
  localparam logic [c_cw-1:0] c_half_last = c_cw'(8 * CLK_DIV - 1);
  localparam logic [3:0]      c_last_bit  = 4'(DATA_BITS - 1);
  localparam logic            c_last_stop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_WAIT   = 3'd5
  } rx_state_t;

  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  // ---------------------------------------------------------------- TX
  tx_state_t             r_tx_state, w_tx_state_next;
  logic [c_cw-1:0]       r_tx_cnt, w_tx_cnt_next;
  logic [3:0]            r_tx_bit, w_tx_bit_next;
  logic                  r_tx_stop, w_tx_stop_next;
  logic [DATA_BITS-1:0]  r_tx_shift, w_tx_shift_next;
  logic                  r_tx_par, w_tx_par_next;
  logic                  r_tx_out, w_tx_out_next;
  logic                  w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == c_bit_last);

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_cnt_next   = w_tx_bit_end ? '0 : r_tx_cnt + 1'b1;
    w_tx_bit_next   = r_tx_bit;
    w_tx_stop_next  = r_tx_stop;
    w_tx_shift_next = r_tx_shift;
    w_tx_par_next   = r_tx_par;
    w_tx_out_next   = r_tx_out;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_next = '0;
        w_tx_out_next = 1'b1;
        if (tx_valid) begin
          w_tx_state_next = TX_START;
          w_tx_shift_next = tx_data;
          w_tx_par_next   = f_parity(tx_data);
          w_tx_out_next   = 1'b0;
        end
      end
      TX_START: if (w_tx_bit_end) begin
        w_tx_state_next = TX_DATA;
        w_tx_bit_next   = '0;
        w_tx_out_next   = r_tx_shift[0];
      end
      TX_DATA: if (w_tx_bit_end) begin
        if (r_tx_bit == c_last_bit) begin
          if (PARITY_EN != 0) begin
            w_tx_state_next = TX_PARITY;
            w_tx_out_next   = r_tx_par;
          end else begin
            w_tx_state_next = TX_STOP;
            w_tx_stop_next  = 1'b0;
            w_tx_out_next   = 1'b1;
          end
        end else begin
          // The shifter always presents the current bit at index 0.
          w_tx_bit_next   = r_tx_bit + 1'b1;
          w_tx_shift_next = r_tx_shift >> 1;
          w_tx_out_next   = r_tx_shift[1];
        end
      end
      TX_PARITY: if (w_tx_bit_end) begin
        w_tx_state_next = TX_STOP;
        w_tx_stop_next  = 1'b0;
        w_tx_out_next   = 1'b1;
      end
      TX_STOP: if (w_tx_bit_end) begin
        if (r_tx_stop == c_last_stop) begin
          w_tx_state_next = TX_IDLE;
        end else begin
          w_tx_stop_next = 1'b1;
        end
        w_tx_out_next = 1'b1;
      end
      default: begin
        w_tx_state_next = TX_IDLE;
        w_tx_out_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_cnt   <= w_tx_cnt_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx_stop  <= w_tx_stop_next;
      r_tx_shift <= w_tx_shift_next;
      r_tx_par   <= w_tx_par_next;
      r_tx_out   <= w_tx_out_next;
    end
  end

  assign tx_ready = (r_tx_state == TX_IDLE);
  assign tx_busy  = (r_tx_state != TX_IDLE);
  assign tx_out   = r_tx_out;

  // ---------------------------------------------------------------- RX
  logic                  r_rx_meta, r_rxs;
  rx_state_t             r_rx_state, w_rx_state_next;
  logic [c_cw-1:0]       r_rx_cnt, w_rx_cnt_next;
  logic [3:0]            r_rx_bit, w_rx_bit_next;
  logic                  r_rx_stop, w_rx_stop_next;
  logic [DATA_BITS-1:0]  r_rx_shift, w_rx_shift_next;
  logic                  r_rx_perr, w_rx_perr_next;
  logic                  r_rx_ferr, w_rx_ferr_next;
  logic                  r_rx_valid, w_rx_valid_next;
  logic [DATA_BITS-1:0]  r_rx_data, w_rx_data_next;
  logic                  r_rx_perr_o, w_rx_perr_o_next;
  logic                  r_rx_ferr_o, w_rx_ferr_o_next;
  logic                  w_rx_sample;

  // The start bit is checked at half a bit; every later sample is a full bit on.
  assign w_rx_sample = (r_rx_state == RX_START) ? (r_rx_cnt == c_half_last)
                                                : (r_rx_cnt == c_bit_last);

  always_comb begin
    w_rx_state_next  = r_rx_state;
    w_rx_cnt_next    = w_rx_sample ? '0 : r_rx_cnt + 1'b1;
    w_rx_bit_next    = r_rx_bit;
    w_rx_stop_next   = r_rx_stop;
    w_rx_shift_next  = r_rx_shift;
    w_rx_perr_next   = r_rx_perr;
    w_rx_ferr_next   = r_rx_ferr;
    w_rx_valid_next  = 1'b0;
    w_rx_data_next   = r_rx_data;
    w_rx_perr_o_next = r_rx_perr_o;
    w_rx_ferr_o_next = r_rx_ferr_o;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_next = '0;
        if (!r_rxs) w_rx_state_next = RX_START;
      end
      RX_START: if (w_rx_sample) begin
        w_rx_state_next = r_rxs ? RX_IDLE : RX_DATA;
        w_rx_bit_next   = '0;
        w_rx_perr_next  = 1'b0;
        w_rx_ferr_next  = 1'b0;
      end
      RX_DATA: if (w_rx_sample) begin
        w_rx_shift_next = {r_rxs, r_rx_shift[DATA_BITS-1:1]};
        if (r_rx_bit == c_last_bit) begin
          w_rx_state_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          w_rx_stop_next  = 1'b0;
        end else begin
          w_rx_bit_next = r_rx_bit + 1'b1;
        end
      end
      RX_PARITY: if (w_rx_sample) begin
        w_rx_perr_next  = (r_rxs != f_parity(r_rx_shift));
        w_rx_state_next = RX_STOP;
      end
      RX_STOP: if (w_rx_sample) begin
        if (r_rx_stop == c_last_stop) begin
          w_rx_valid_next  = 1'b1;
          w_rx_data_next   = r_rx_shift;
          w_rx_perr_o_next = r_rx_perr;
          w_rx_ferr_o_next = r_rx_ferr | ~r_rxs;
          w_rx_state_next  = r_rxs ? RX_IDLE : RX_WAIT;
        end else begin
          w_rx_stop_next = 1'b1;
          w_rx_ferr_next = r_rx_ferr | ~r_rxs;
        end
      end
      RX_WAIT: begin
        w_rx_cnt_next = '0;
        if (r_rxs) w_rx_state_next = RX_IDLE;
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta   <= 1'b1;
      r_rxs       <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_stop   <= 1'b0;
      r_rx_shift  <= '0;
      r_rx_perr   <= 1'b0;
      r_rx_ferr   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_perr_o <= 1'b0;
      r_rx_ferr_o <= 1'b0;
    end else begin
      r_rx_meta   <= rx_in;
      r_rxs       <= r_rx_meta;
      r_rx_state  <= w_rx_state_next;
      r_rx_cnt    <= w_rx_cnt_next;
      r_rx_bit    <= w_rx_bit_next;
      r_rx_stop   <= w_rx_stop_next;
      r_rx_shift  <= w_rx_shift_next;
      r_rx_perr   <= w_rx_perr_next;
      r_rx_ferr   <= w_rx_ferr_next;
      r_rx_valid  <= w_rx_valid_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_perr_o <= w_rx_perr_o_next;
      r_rx_ferr_o <= w_rx_ferr_o_next;
    end
  end

  assign rx_valid      = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign rx_parity_err = r_rx_perr_o;
  assign rx_frame_err  = r_rx_ferr_o;
  assign rx_busy       = (r_rx_state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_param
// Function : Directed self-checking bench for uart_param (9O1 and 8N2 builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_param;

  localparam int BIT = 64;   // 16 * CLK_DIV with CLK_DIV = 4

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       tx_valid, tx_ready, tx_out, tx_busy;
  logic [8:0] tx_data;
  logic       loopback, rx_drive, rx_in;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_busy;
  logic [8:0] rx_data;

  logic       tx_valid_8, tx_ready_8, tx_out_8, tx_busy_8;
  logic [7:0] tx_data_8, rx_data_8;
  logic       rx_valid_8, rx_parity_err_8, rx_frame_err_8, rx_busy_8;

  assign rx_in = loopback ? tx_out : rx_drive;

  uart_param #(.CLK_DIV(4), .DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_out(tx_out), .tx_busy(tx_busy),
    .rx_in(rx_in), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  uart_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(1), .STOP_BITS(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .tx_valid(tx_valid_8), .tx_ready(tx_ready_8), .tx_data(tx_data_8), .tx_out(tx_out_8), .tx_busy(tx_busy_8),
    .rx_in(tx_out_8), .rx_valid(rx_valid_8), .rx_data(rx_data_8),
    .rx_parity_err(rx_parity_err_8), .rx_frame_err(rx_frame_err_8), .rx_busy(rx_busy_8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-derived line sequences (start, data LSB first, parity/stop).
  logic exp1 [0:11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic exp8 [0:10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  logic [8:0] q_data[$];
  logic       q_perr[$], q_ferr[$];
  logic [7:0] q8_data[$];
  logic       q8_perr[$], q8_ferr[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      q_data.push_back(rx_data); q_perr.push_back(rx_parity_err); q_ferr.push_back(rx_frame_err);
    end
    if (rx_valid_8 === 1'b1) begin
      q8_data.push_back(rx_data_8); q8_perr.push_back(rx_parity_err_8); q8_ferr.push_back(rx_frame_err_8);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx_ready(input string tag, input int budget);
    int n = 0;
    while (tx_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_ready), 32'd1);
  endtask

  // Drives bits LSB first, one bit period each, starting just after a rising edge.
  task automatic drive_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drive = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [11:0] frame9(input logic [8:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  initial begin
    reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; loopback = 1'b0; rx_drive = 1'b1;
    tx_valid_8 = 1'b0; tx_data_8 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_perr", 32'(rx_parity_err), 32'd0);
    check("rst_rx_ferr", 32'(rx_frame_err), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check("rst_tx_out_8", 32'(tx_out_8), 32'd1);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // TX frame 0x1A5, line not looped back
    tx_data = 9'h1A5; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("tx1_ready_low", 32'(tx_ready), 32'd0);
    check("tx1_busy", 32'(tx_busy), 32'd1);
    for (int k = 0; k < 768; k++) begin
      if ((k % BIT) == 0 || (k % BIT) == BIT - 1)
        check($sformatf("tx1_bit%0d_c%0d", k / BIT, k % BIT), 32'(tx_out), 32'(exp1[k / BIT]));
      if (k == 767) check("tx1_ready_c767", 32'(tx_ready), 32'd0);
      @(negedge clk);
    end
    check("tx1_ready_c768", 32'(tx_ready), 32'd1);
    repeat (4) @(negedge clk);

    // Loopback, three words back-to-back with tx_valid held
    loopback = 1'b1;
    q_data.delete(); q_perr.delete(); q_ferr.delete();
    @(negedge clk);
    tx_data = 9'h000; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 9'h1FF;
    repeat (673) @(negedge clk);
    check("lb_parity_of_000", 32'(tx_out), 32'd1);
    wait_tx_ready("lb_ready1", 2000);
    @(posedge clk); #1;
    tx_data = 9'h155;
    wait_tx_ready("lb_ready2", 2000);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_tx_ready("lb_ready3", 2000);
    repeat (BIT) @(negedge clk);
    check("lb_count", 32'(q_data.size()), 32'd3);
    check("lb_d0", 32'(q_data[0]), 32'h000);
    check("lb_d1", 32'(q_data[1]), 32'h1FF);
    check("lb_d2", 32'(q_data[2]), 32'h155);
    check("lb_err0", {30'd0, q_perr[0], q_ferr[0]}, 32'd0);
    check("lb_err1", {30'd0, q_perr[1], q_ferr[1]}, 32'd0);
    check("lb_err2", {30'd0, q_perr[2], q_ferr[2]}, 32'd0);

    // Parity error: 0x0A5 has four ones, odd parity is 1, send 0
    loopback = 1'b0;
    q_data.delete(); q_perr.delete(); q_ferr.delete();
    @(posedge clk); #1;
    drive_bits(frame9(9'h0A5, 1'b0, 1'b1), 12);
    repeat (2 * BIT) @(negedge clk);
    check("perr_count", 32'(q_data.size()), 32'd1);
    check("perr_data", 32'(q_data[0]), 32'h0A5);
    check("perr_flag", 32'(q_perr[0]), 32'd1);
    check("perr_ferr", 32'(q_ferr[0]), 32'd0);

    // Frame error followed by a 30-bit break
    q_data.delete(); q_perr.delete(); q_ferr.delete();
    @(posedge clk); #1;
    drive_bits(frame9(9'h055, 1'b1, 1'b0), 12);
    rx_drive = 1'b0;
    repeat (30 * BIT) @(posedge clk);
    #1;
    check("ferr_count", 32'(q_data.size()), 32'd1);
    check("ferr_data", 32'(q_data[0]), 32'h055);
    check("ferr_flag", 32'(q_ferr[0]), 32'd1);
    check("ferr_perr", 32'(q_perr[0]), 32'd0);
    rx_drive = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("brk_no_strobe", 32'(q_data.size()), 32'd1);
    check("brk_busy_clear", 32'(rx_busy), 32'd0);
    q_data.delete(); q_perr.delete(); q_ferr.delete();
    @(posedge clk); #1;
    drive_bits(frame9(9'h123, 1'b1, 1'b1), 12);
    repeat (2 * BIT) @(negedge clk);
    check("after_brk_count", 32'(q_data.size()), 32'd1);
    check("after_brk_data", 32'(q_data[0]), 32'h123);
    check("after_brk_err", {30'd0, q_perr[0], q_ferr[0]}, 32'd0);

    // Glitch shorter than half a bit
    q_data.delete(); q_perr.delete(); q_ferr.delete();
    @(posedge clk); #1;
    rx_drive = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rx_drive = 1'b1;
    @(negedge clk);
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    repeat (BIT) @(negedge clk);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    repeat (2 * BIT) @(negedge clk);
    check("glitch_no_strobe", 32'(q_data.size()), 32'd0);

    // Reset during data bit 4 of a looped-back frame
    loopback = 1'b1;
    @(negedge clk);
    tx_data = 9'h0A5; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (341) @(negedge clk);
    check("mid_tx_busy", 32'(tx_busy), 32'd1);
    check("mid_rx_busy", 32'(rx_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx_out", 32'(tx_out), 32'd1);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_rx_busy", 32'(rx_busy), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (13 * BIT) @(negedge clk);
    check("mid_rst_no_strobe", 32'(q_data.size()), 32'd0);
    tx_data = 9'h16C; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_tx_ready("post_rst_ready", 2000);
    repeat (BIT) @(negedge clk);
    check("post_rst_count", 32'(q_data.size()), 32'd1);
    check("post_rst_data", 32'(q_data[0]), 32'h16C);
    check("post_rst_err", {30'd0, q_perr[0], q_ferr[0]}, 32'd0);

    // 8N2 build, looped back on itself
    @(negedge clk);
    tx_data_8 = 8'hC3; tx_valid_8 = 1'b1;
    @(posedge clk); #1;
    tx_valid_8 = 1'b0;
    @(negedge clk);
    check("v8_ready_low", 32'(tx_ready_8), 32'd0);
    for (int k = 0; k < 704; k++) begin
      if ((k % BIT) == BIT / 2)
        check($sformatf("v8_bit%0d", k / BIT), 32'(tx_out_8), 32'(exp8[k / BIT]));
      if (k == 703) check("v8_ready_c703", 32'(tx_ready_8), 32'd0);
      @(negedge clk);
    end
    check("v8_ready_c704", 32'(tx_ready_8), 32'd1);
    repeat (BIT) @(negedge clk);
    check("v8_count", 32'(q8_data.size()), 32'd1);
    check("v8_data", 32'(q8_data[0]), 32'hC3);
    check("v8_err", {30'd0, q8_perr[0], q8_ferr[0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
